// File: rtl/display_pkg.sv
// Shared types, constants and the hex-to-7-segment map for the display scan controller.
package display_pkg;

  // Scan phase: all-off dead time, then one digit lit.
  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  // Active-low segment pattern with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7_f(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_decoder7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module decoder7
  import display_pkg::*;
(
  input  logic [3:0] In,
  output logic [6:0] Out
);

  // Pure table lookup, shared by all digits of the scan.
  always_comb begin
    Out = hex7_f(In);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for N common-anode hex digits with
// frame-synchronous double buffering and dead time between digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SHOW_CYCLES = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Load,
  output logic                  Ready,
  input  logic [4*N_DIGITS-1:0] Data,
  input  logic [N_DIGITS-1:0]   Blank,
  output logic [6:0]            Seg,
  output logic [N_DIGITS-1:0]   Dig_en
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int CMAX = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
  // Keep the counter at least one bit wide when both phases are one cycle.
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  scan_state_t           state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  frame_end;

  logic [4*N_DIGITS-1:0] pend_data, act_data;
  logic [N_DIGITS-1:0]   pend_blank, act_blank;
  logic                  pend_v, pend_v_nxt;
  logic                  accept;

  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_nxt;
  logic [N_DIGITS-1:0]   dig_nxt;

  assign accept = Load & Ready;
  assign nib    = act_data[{idx, 2'b00} +: 4];

  decoder7 u_dec (
    .In  (nib),
    .Out (dec_seg)
  );

  // Phase/digit sequencing register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= DEAD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next phase, digit advance and frame-boundary detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = DEAD;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            frame_end = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = DEAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output drive for the coming cycle; idx is unchanged whenever the next phase is SHOW,
  // and the active buffer only changes on a SHOW->DEAD edge, so current values are safe.
  always_comb begin
    seg_nxt = SEG_BLANK;
    dig_nxt = '1;
    if (state_nxt == SHOW && !act_blank[idx]) begin
      seg_nxt      = dec_seg;
      dig_nxt[idx] = 1'b0;
    end
  end

  // Pending flag: set on accept, cleared when the frame boundary consumes it.
  // Accept needs pend_v low, so the two cannot collide on one edge.
  always_comb begin
    pend_v_nxt = pend_v;
    if (accept) begin
      pend_v_nxt = 1'b1;
    end else if (frame_end && pend_v) begin
      pend_v_nxt = 1'b0;
    end
  end

  // Double buffer, handshake and registered display outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_data  <= '0;
      pend_blank <= '1;
      pend_v     <= 1'b0;
      act_data   <= '0;
      act_blank  <= '1;
      Ready      <= 1'b1;
      Seg        <= SEG_BLANK;
      Dig_en     <= '1;
    end else begin
      if (accept) begin
        pend_data  <= Data;
        pend_blank <= Blank;
      end
      if (frame_end && pend_v) begin
        act_data  <= pend_data;
        act_blank <= pend_blank;
      end
      pend_v <= pend_v_nxt;
      Ready  <= !pend_v_nxt;
      Seg    <= seg_nxt;
      Dig_en <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, SHOW_CYCLES=4, DEAD_CYCLES=1.
module tb_display_scan_ctrl;

  logic        Clk   = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Load  = 1'b0;
  logic        Ready;
  logic [15:0] Data  = '0;
  logic [3:0]  Blank = '0;
  logic [6:0]  Seg;
  logic [3:0]  Dig_en;

  int total = 0;
  int bad   = 0;
  bit tb_pend = 1'b0;

  display_scan_ctrl #(
    .N_DIGITS    (4),
    .SHOW_CYCLES (4),
    .DEAD_CYCLES (1)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Load   (Load),
    .Ready  (Ready),
    .Data   (Data),
    .Blank  (Blank),
    .Seg    (Seg),
    .Dig_en (Dig_en)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs nedges clock edges of one frame (edge k=1..20 after the previous boundary),
  // optionally pulsing Load before edges off_a / off_b, checking outputs after each edge.
  task automatic run_frame(input string name, input logic [15:0] w, input logic [3:0] bl,
                           input int nedges,
                           input int off_a, input logic [15:0] da, input logic [3:0] ba,
                           input int off_b, input logic [15:0] db, input logic [3:0] bb);
    for (int k = 1; k <= nedges; k++) begin
      bit         acc;
      int         di;
      int         ph;
      logic [3:0] ed;
      logic [6:0] es;
      Load = 1'b0;
      if (k == off_a) begin Load = 1'b1; Data = da; Blank = ba; end
      if (k == off_b) begin Load = 1'b1; Data = db; Blank = bb; end
      acc = Load && !tb_pend;
      @(posedge Clk);
      @(negedge Clk);
      Load = 1'b0;
      if (acc) tb_pend = 1'b1;
      else if (k == 20) tb_pend = 1'b0;
      di = (k - 1) / 5;
      ph = (k - 1) % 5;
      ed = 4'hF;
      es = 7'h7F;
      if (ph != 4 && !bl[di]) begin
        ed[di] = 1'b0;
        es     = exp_seg(w[4*di +: 4]);
      end
      chk($sformatf("%s e%0d dig_en", name, k), 16'(Dig_en), 16'(ed));
      chk($sformatf("%s e%0d seg", name, k), 16'(Seg), 16'(es));
      chk($sformatf("%s e%0d ready", name, k), 16'(Ready), 16'(!tb_pend));
    end
  endtask

  initial begin
    // Reset held: outputs at reset values.
    #1 Rst_n = 1'b0;
    #8;
    chk("rst dig_en", 16'(Dig_en), 16'hF);
    chk("rst seg", 16'(Seg), 16'h7F);
    chk("rst ready", 16'(Ready), 16'h1);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Frame 0 blank; accept 1234 at edge 3, ignored AAAA at edge 10.
    run_frame("f0", 16'h0000, 4'b1111, 20, 3, 16'h1234, 4'b0000, 10, 16'hAAAA, 4'b0000);
    // Frame 1 shows 1234; queue F000 with digits 0-2 blanked.
    run_frame("f1", 16'h1234, 4'b0000, 20, 7, 16'hF000, 4'b0111, 0, 16'h0, 4'b0);
    // Frame 2 shows F000 on digit 3 only; load accepted on the boundary edge.
    run_frame("f2", 16'hF000, 4'b0111, 20, 20, 16'h5A0C, 4'b0000, 0, 16'h0, 4'b0);
    // Frame 3 still shows F000; boundary load waits a full frame.
    run_frame("f3", 16'hF000, 4'b0111, 20, 0, 16'h0, 4'b0, 0, 16'h0, 4'b0);
    // Frame 4 shows 5A0C.
    run_frame("f4", 16'h5A0C, 4'b0000, 20, 0, 16'h0, 4'b0, 0, 16'h0, 4'b0);
    // Frame 5 up to slot 2 lit, with a pending load that reset must discard.
    run_frame("f5", 16'h5A0C, 4'b0000, 11, 3, 16'h1111, 4'b0000, 0, 16'h0, 4'b0);

    // Asynchronous reset mid-SHOW, checked before the next clock edge.
    #2 Rst_n = 1'b0;
    #1;
    chk("async dig_en", 16'(Dig_en), 16'hF);
    chk("async seg", 16'(Seg), 16'h7F);
    chk("async ready", 16'(Ready), 16'h1);
    tb_pend = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Two blank frames: active buffer reset and the pending load dropped.
    run_frame("r0", 16'h0000, 4'b1111, 20, 0, 16'h0, 4'b0, 0, 16'h0, 4'b0);
    run_frame("r1", 16'h0000, 4'b1111, 20, 0, 16'h0, 4'b0, 0, 16'h0, 4'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
